// File: rtl/reorder_buffer.sv
// Reorder buffer for a 2-wide OoO core, indexed by RRF tag.
// Tracks completion and retires up to two entries per cycle in order.
module reorder_buffer #(
  parameter int RRF_SEL     = 6,
  parameter int ROB_SEL     = 6,
  parameter int INSN_LEN    = 32,
  parameter int ADDR_LEN    = 32,
  parameter int REG_SEL     = 5,
  parameter int GSH_BHR_LEN = 10
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   dp1_i,
  input  logic [RRF_SEL-1:0]     dp1_addr_i,
  input  logic [INSN_LEN-1:0]    pc_dp1_i,
  input  logic                   storebit_dp1_i,
  input  logic                   dstvalid_dp1_i,
  input  logic [REG_SEL-1:0]     dst_dp1_i,
  input  logic [GSH_BHR_LEN-1:0] bhr_dp1_i,
  input  logic                   isbranch_dp1_i,
  input  logic                   dp2_i,
  input  logic [RRF_SEL-1:0]     dp2_addr_i,
  input  logic [INSN_LEN-1:0]    pc_dp2_i,
  input  logic                   storebit_dp2_i,
  input  logic                   dstvalid_dp2_i,
  input  logic [REG_SEL-1:0]     dst_dp2_i,
  input  logic [GSH_BHR_LEN-1:0] bhr_dp2_i,
  input  logic                   isbranch_dp2_i,
  input  logic                   finish_ex_alu1_i,
  input  logic [RRF_SEL-1:0]     finish_ex_alu1_addr_i,
  input  logic                   finish_ex_alu2_i,
  input  logic [RRF_SEL-1:0]     finish_ex_alu2_addr_i,
  input  logic                   finish_ex_mul_i,
  input  logic [RRF_SEL-1:0]     finish_ex_mul_addr_i,
  input  logic                   finish_ex_ldst_i,
  input  logic [RRF_SEL-1:0]     finish_ex_ldst_addr_i,
  input  logic                   finish_ex_branch_i,
  input  logic [RRF_SEL-1:0]     finish_ex_branch_addr_i,
  input  logic                   finish_ex_branch_brcond_i,
  input  logic [ADDR_LEN-1:0]    finish_ex_branch_jmpaddr_i,
  input  logic [RRF_SEL-1:0]     dispatch_ptr_i,
  input  logic [RRF_SEL:0]       rrf_freenum_i,
  output logic [ROB_SEL-1:0]     commit_ptr_1_o,
  output logic [ROB_SEL-1:0]     commit_ptr_2_o,
  output logic [1:0]             comnum_o,
  output logic                   store_commit_o,
  output logic                   arfwe_1_o,
  output logic                   arfwe_2_o,
  output logic [REG_SEL-1:0]     dst_arf_1_o,
  output logic [REG_SEL-1:0]     dst_arf_2_o,
  output logic                   combranch_o,
  output logic [ADDR_LEN-1:0]    pc_combranch_o,
  output logic [GSH_BHR_LEN-1:0] bhr_combranch_o,
  output logic [ADDR_LEN-1:0]    jmpaddr_combranch_o,
  output logic                   brcond_combranch_o
);

  localparam int ENTRIES = 1 << RRF_SEL;

  logic [ENTRIES-1:0]     r_finish;
  logic [ENTRIES-1:0]     r_storebit;
  logic [ENTRIES-1:0]     r_dstvalid;
  logic [ENTRIES-1:0]     r_isbranch;
  logic [ENTRIES-1:0]     r_brcond;
  logic [REG_SEL-1:0]     r_dst     [ENTRIES];
  logic [GSH_BHR_LEN-1:0] r_bhr     [ENTRIES];
  logic [INSN_LEN-1:0]    r_pc      [ENTRIES];
  logic [ADDR_LEN-1:0]    r_jmpaddr [ENTRIES];
  logic [ROB_SEL-1:0]     r_comptr;

  logic [ROB_SEL-1:0]  w_c1;
  logic [ROB_SEL-1:0]  w_c2;
  logic [RRF_SEL:0]    w_used;
  logic                w_commit1;
  logic                w_commit2;
  logic                w_br1;
  logic [ROB_SEL-1:0]  w_bsel;
  logic [INSN_LEN-1:0] w_pc_sel;
  logic [ENTRIES-1:0]  w_finish_nxt;
  logic                w_unused;

  assign w_unused = ^dispatch_ptr_i;

  assign w_c1   = r_comptr;
  assign w_c2   = r_comptr + 1'b1;
  assign w_used = (RRF_SEL+1)'(ENTRIES) - rrf_freenum_i;

  assign w_commit1 = (w_used >= 1) & r_finish[w_c1];
  assign w_commit2 = w_commit1
                   & (w_used >= 2)
                   & r_finish[w_c2]
                   & ~(r_storebit[w_c1] & r_storebit[w_c2])
                   & ~(r_isbranch[w_c1] & r_isbranch[w_c2]);

  assign comnum_o = {1'b0, w_commit1} + {1'b0, w_commit2};

  assign commit_ptr_1_o = w_c1;
  assign commit_ptr_2_o = w_c2;

  assign arfwe_1_o   = w_commit1 & r_dstvalid[w_c1];
  assign arfwe_2_o   = w_commit2 & r_dstvalid[w_c2];
  assign dst_arf_1_o = r_dst[w_c1];
  assign dst_arf_2_o = r_dst[w_c2];

  assign store_commit_o = (w_commit1 & r_storebit[w_c1])
                        | (w_commit2 & r_storebit[w_c2]);

  // Slot 1 has priority for the single branch report
  assign w_br1       = w_commit1 & r_isbranch[w_c1];
  assign combranch_o = w_br1 | (w_commit2 & r_isbranch[w_c2]);
  assign w_bsel      = w_br1 ? w_c1 : w_c2;

  assign w_pc_sel            = r_pc[w_bsel];
  assign bhr_combranch_o     = r_bhr[w_bsel];
  assign jmpaddr_combranch_o = r_jmpaddr[w_bsel];
  assign brcond_combranch_o  = r_brcond[w_bsel];

  generate
    if (ADDR_LEN == INSN_LEN) begin : g_pc_eq
      assign pc_combranch_o = w_pc_sel;
    end else if (ADDR_LEN > INSN_LEN) begin : g_pc_ext
      assign pc_combranch_o =
        {{(ADDR_LEN-INSN_LEN){1'b0}}, w_pc_sel};
    end else begin : g_pc_trunc
      assign pc_combranch_o = w_pc_sel[ADDR_LEN-1:0];
    end
  endgenerate

  // Dispatch clears last so it overrides a same-cycle finish
  always_comb begin
    w_finish_nxt = r_finish;
    if (w_commit1) w_finish_nxt[w_c1] = 1'b0;
    if (w_commit2) w_finish_nxt[w_c2] = 1'b0;
    if (finish_ex_alu1_i)
      w_finish_nxt[finish_ex_alu1_addr_i] = 1'b1;
    if (finish_ex_alu2_i)
      w_finish_nxt[finish_ex_alu2_addr_i] = 1'b1;
    if (finish_ex_mul_i)
      w_finish_nxt[finish_ex_mul_addr_i] = 1'b1;
    if (finish_ex_ldst_i)
      w_finish_nxt[finish_ex_ldst_addr_i] = 1'b1;
    if (finish_ex_branch_i)
      w_finish_nxt[finish_ex_branch_addr_i] = 1'b1;
    if (dp1_i) w_finish_nxt[dp1_addr_i] = 1'b0;
    if (dp2_i) w_finish_nxt[dp2_addr_i] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_finish <= '0;
      r_comptr <= '0;
    end else begin
      r_finish <= w_finish_nxt;
      r_comptr <= r_comptr + ROB_SEL'(comnum_o);
    end
  end

  always_ff @(posedge clk_i) begin
    if (dp1_i) begin
      r_storebit[dp1_addr_i] <= storebit_dp1_i;
      r_dstvalid[dp1_addr_i] <= dstvalid_dp1_i;
      r_isbranch[dp1_addr_i] <= isbranch_dp1_i;
      r_dst[dp1_addr_i]      <= dst_dp1_i;
      r_bhr[dp1_addr_i]      <= bhr_dp1_i;
      r_pc[dp1_addr_i]       <= pc_dp1_i;
    end
    if (dp2_i) begin
      r_storebit[dp2_addr_i] <= storebit_dp2_i;
      r_dstvalid[dp2_addr_i] <= dstvalid_dp2_i;
      r_isbranch[dp2_addr_i] <= isbranch_dp2_i;
      r_dst[dp2_addr_i]      <= dst_dp2_i;
      r_bhr[dp2_addr_i]      <= bhr_dp2_i;
      r_pc[dp2_addr_i]       <= pc_dp2_i;
    end
    if (finish_ex_branch_i) begin
      r_brcond[finish_ex_branch_addr_i] <=
        finish_ex_branch_brcond_i;
      r_jmpaddr[finish_ex_branch_addr_i] <=
        finish_ex_branch_jmpaddr_i;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer.
// Expected commit records are queued and matched per cycle.
module tb_reorder_buffer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        dp1_i, dp2_i;
  logic [5:0]  dp1_addr_i, dp2_addr_i;
  logic [31:0] pc_dp1_i, pc_dp2_i;
  logic        storebit_dp1_i, storebit_dp2_i;
  logic        dstvalid_dp1_i, dstvalid_dp2_i;
  logic [4:0]  dst_dp1_i, dst_dp2_i;
  logic [9:0]  bhr_dp1_i, bhr_dp2_i;
  logic        isbranch_dp1_i, isbranch_dp2_i;
  logic        f_alu1, f_alu2, f_mul, f_ldst, f_br;
  logic [5:0]  a_alu1, a_alu2, a_mul, a_ldst, a_br;
  logic        f_brcond;
  logic [31:0] f_jmp;
  logic [5:0]  dispatch_ptr_i;
  logic [6:0]  rrf_freenum_i;

  logic [5:0]  commit_ptr_1_o, commit_ptr_2_o;
  logic [1:0]  comnum_o;
  logic        store_commit_o, arfwe_1_o, arfwe_2_o;
  logic [4:0]  dst_arf_1_o, dst_arf_2_o;
  logic        combranch_o, brcond_combranch_o;
  logic [31:0] pc_combranch_o, jmpaddr_combranch_o;
  logic [9:0]  bhr_combranch_o;

  reorder_buffer dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .dp1_i(dp1_i), .dp1_addr_i(dp1_addr_i),
    .pc_dp1_i(pc_dp1_i), .storebit_dp1_i(storebit_dp1_i),
    .dstvalid_dp1_i(dstvalid_dp1_i), .dst_dp1_i(dst_dp1_i),
    .bhr_dp1_i(bhr_dp1_i), .isbranch_dp1_i(isbranch_dp1_i),
    .dp2_i(dp2_i), .dp2_addr_i(dp2_addr_i),
    .pc_dp2_i(pc_dp2_i), .storebit_dp2_i(storebit_dp2_i),
    .dstvalid_dp2_i(dstvalid_dp2_i), .dst_dp2_i(dst_dp2_i),
    .bhr_dp2_i(bhr_dp2_i), .isbranch_dp2_i(isbranch_dp2_i),
    .finish_ex_alu1_i(f_alu1), .finish_ex_alu1_addr_i(a_alu1),
    .finish_ex_alu2_i(f_alu2), .finish_ex_alu2_addr_i(a_alu2),
    .finish_ex_mul_i(f_mul), .finish_ex_mul_addr_i(a_mul),
    .finish_ex_ldst_i(f_ldst), .finish_ex_ldst_addr_i(a_ldst),
    .finish_ex_branch_i(f_br), .finish_ex_branch_addr_i(a_br),
    .finish_ex_branch_brcond_i(f_brcond),
    .finish_ex_branch_jmpaddr_i(f_jmp),
    .dispatch_ptr_i(dispatch_ptr_i),
    .rrf_freenum_i(rrf_freenum_i),
    .commit_ptr_1_o(commit_ptr_1_o),
    .commit_ptr_2_o(commit_ptr_2_o),
    .comnum_o(comnum_o),
    .store_commit_o(store_commit_o),
    .arfwe_1_o(arfwe_1_o), .arfwe_2_o(arfwe_2_o),
    .dst_arf_1_o(dst_arf_1_o), .dst_arf_2_o(dst_arf_2_o),
    .combranch_o(combranch_o),
    .pc_combranch_o(pc_combranch_o),
    .bhr_combranch_o(bhr_combranch_o),
    .jmpaddr_combranch_o(jmpaddr_combranch_o),
    .brcond_combranch_o(brcond_combranch_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [5:0]  p1;
    logic [1:0]  n;
    logic        we1, we2;
    logic [4:0]  d1, d2;
    logic        st, br, brc;
    logic [31:0] pc, jmp;
    logic [9:0]  bhr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(int p, int n, bit w1, int d1,
                              bit w2, int d2, bit st);
    exp_t e;
    e.p1 = 6'(p);   e.n = 2'(n);
    e.we1 = w1;     e.d1 = 5'(d1);
    e.we2 = w2;     e.d2 = 5'(d2);
    e.st = st;      e.br = 1'b0;   e.brc = 1'b0;
    e.pc = '0;      e.jmp = '0;    e.bhr = '0;
    return e;
  endfunction

  function automatic exp_t mkbr(int p, bit w1, int d1, int pc,
                                int jmp, int bhr, bit brc);
    exp_t e;
    e = mk(p, 1, w1, d1, 1'b0, 0, 1'b0);
    e.br = 1'b1;     e.brc = brc;
    e.pc = 32'(pc);  e.jmp = 32'(jmp);  e.bhr = 10'(bhr);
    return e;
  endfunction

  task automatic idle(int p);
    exp_q.push_back(mk(p, 0, 1'b0, 0, 1'b0, 0, 1'b0));
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic observe();
    exp_t e;
    logic [5:0] p2;
    #1;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard: observed empty expected entry");
    end
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      p2 = e.p1 + 6'd1;
      chk("commit_ptr_1", 32'(commit_ptr_1_o), 32'(e.p1));
      chk("commit_ptr_2", 32'(commit_ptr_2_o), 32'(p2));
      chk("comnum", 32'(comnum_o), 32'(e.n));
      chk("arfwe_1", 32'(arfwe_1_o), 32'(e.we1));
      chk("arfwe_2", 32'(arfwe_2_o), 32'(e.we2));
      chk("store_commit", 32'(store_commit_o), 32'(e.st));
      chk("combranch", 32'(combranch_o), 32'(e.br));
      if (e.we1) chk("dst_arf_1", 32'(dst_arf_1_o), 32'(e.d1));
      if (e.we2) chk("dst_arf_2", 32'(dst_arf_2_o), 32'(e.d2));
      if (e.br) begin
        chk("pc_br", pc_combranch_o, e.pc);
        chk("jmp_br", jmpaddr_combranch_o, e.jmp);
        chk("bhr_br", 32'(bhr_combranch_o), 32'(e.bhr));
        chk("brcond_br", 32'(brcond_combranch_o), 32'(e.brc));
      end
    end
  endtask

  task automatic clr();
    dp1_i = 0; dp2_i = 0;
    f_alu1 = 0; f_alu2 = 0; f_mul = 0; f_ldst = 0; f_br = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    clr();
  endtask

  task automatic dp1(int a, int pc, bit st, bit dv, int d,
                     int bhr, bit br);
    dp1_i = 1; dp1_addr_i = 6'(a); pc_dp1_i = 32'(pc);
    storebit_dp1_i = st; dstvalid_dp1_i = dv;
    dst_dp1_i = 5'(d); bhr_dp1_i = 10'(bhr);
    isbranch_dp1_i = br;
  endtask

  task automatic dp2(int a, int pc, bit st, bit dv, int d,
                     int bhr, bit br);
    dp2_i = 1; dp2_addr_i = 6'(a); pc_dp2_i = 32'(pc);
    storebit_dp2_i = st; dstvalid_dp2_i = dv;
    dst_dp2_i = 5'(d); bhr_dp2_i = 10'(bhr);
    isbranch_dp2_i = br;
  endtask

  initial begin
    clr();
    dp1_addr_i = '0; dp2_addr_i = '0;
    pc_dp1_i = '0; pc_dp2_i = '0;
    storebit_dp1_i = 0; storebit_dp2_i = 0;
    dstvalid_dp1_i = 0; dstvalid_dp2_i = 0;
    dst_dp1_i = '0; dst_dp2_i = '0;
    bhr_dp1_i = '0; bhr_dp2_i = '0;
    isbranch_dp1_i = 0; isbranch_dp2_i = 0;
    a_alu1 = '0; a_alu2 = '0; a_mul = '0; a_ldst = '0; a_br = '0;
    f_brcond = 0; f_jmp = '0;
    dispatch_ptr_i = '0;
    rrf_freenum_i = 7'd64;
    reset_i = 0;
    #10;
    reset_i = 1;
    #2;

    // single commit of entry 0
    dp1(0, 'h0, 0, 1, 1, 0, 0);
    idle(0); observe(); tick();
    rrf_freenum_i = 7'd63;
    f_alu1 = 1; a_alu1 = 6'd0;
    idle(0); observe(); tick();
    exp_q.push_back(mk(0, 1, 1, 1, 0, 0, 0)); observe(); tick();

    // dual commit 1,2
    rrf_freenum_i = 7'd64;
    dp1(1, 'h4, 0, 1, 2, 0, 0);
    dp2(2, 'h8, 0, 1, 3, 0, 0);
    idle(1); observe(); tick();
    rrf_freenum_i = 7'd62;
    f_alu1 = 1; a_alu1 = 6'd1; f_alu2 = 1; a_alu2 = 6'd2;
    idle(1); observe(); tick();
    exp_q.push_back(mk(1, 2, 1, 2, 1, 3, 0)); observe(); tick();

    // two stores serialize
    rrf_freenum_i = 7'd64;
    dp1(3, 'hc, 1, 0, 0, 0, 0);
    dp2(4, 'h10, 1, 0, 0, 0, 0);
    idle(3); observe(); tick();
    rrf_freenum_i = 7'd62;
    f_ldst = 1; a_ldst = 6'd3; f_mul = 1; a_mul = 6'd4;
    idle(3); observe(); tick();
    exp_q.push_back(mk(3, 1, 0, 0, 0, 0, 1)); observe(); tick();
    rrf_freenum_i = 7'd63;
    exp_q.push_back(mk(4, 1, 0, 0, 0, 0, 1)); observe(); tick();

    // branch; dispatch beats a same-cycle finish
    rrf_freenum_i = 7'd64;
    dp1(5, 'h40, 0, 0, 0, 'h2a, 1);
    f_alu1 = 1; a_alu1 = 6'd5;
    idle(5); observe(); tick();
    rrf_freenum_i = 7'd63;
    f_br = 1; a_br = 6'd5; f_brcond = 1; f_jmp = 32'h100;
    idle(5); observe(); tick();
    exp_q.push_back(mkbr(5, 0, 0, 'h40, 'h100, 'h2a, 1));
    observe(); tick();

    // two branches serialize
    rrf_freenum_i = 7'd64;
    dp1(6, 'h60, 0, 1, 7, 'h11, 1);
    dp2(7, 'h70, 0, 1, 8, 'h22, 1);
    idle(6); observe(); tick();
    rrf_freenum_i = 7'd62;
    f_br = 1; a_br = 6'd7; f_brcond = 1; f_jmp = 32'h300;
    idle(6); observe(); tick();
    f_br = 1; a_br = 6'd6; f_brcond = 0; f_jmp = 32'h200;
    idle(6); observe(); tick();
    exp_q.push_back(mkbr(6, 1, 7, 'h60, 'h200, 'h11, 0));
    observe(); tick();
    rrf_freenum_i = 7'd63;
    exp_q.push_back(mkbr(7, 1, 8, 'h70, 'h300, 'h22, 1));
    observe(); tick();

    // advance comptr to 62 in pairs
    for (int k = 8; k <= 60; k += 2) begin
      rrf_freenum_i = 7'd64;
      dp1(k, k * 4, 0, 1, k % 32, 0, 0);
      dp2(k + 1, k * 4 + 4, 0, 1, (k + 1) % 32, 0, 0);
      tick();
      rrf_freenum_i = 7'd62;
      f_alu1 = 1; a_alu1 = 6'(k);
      f_alu2 = 1; a_alu2 = 6'(k + 1);
      tick();
      exp_q.push_back(mk(k, 2, 1, k % 32, 1, (k + 1) % 32, 0));
      observe(); tick();
    end
    rrf_freenum_i = 7'd64;
    dp1(62, 'hf8, 0, 0, 0, 0, 0);
    tick();
    rrf_freenum_i = 7'd63;
    f_alu1 = 1; a_alu1 = 6'd62;
    tick();
    exp_q.push_back(mk(62, 1, 0, 0, 0, 0, 0)); observe(); tick();

    // wrap: 63 and 0
    rrf_freenum_i = 7'd64;
    dp1(63, 'hfc, 0, 1, 30, 0, 0);
    dp2(0, 'h100, 0, 1, 31, 0, 0);
    idle(63); observe(); tick();
    rrf_freenum_i = 7'd62;
    f_alu2 = 1; a_alu2 = 6'd63; f_ldst = 1; a_ldst = 6'd0;
    tick();
    exp_q.push_back(mk(63, 2, 1, 30, 1, 31, 0)); observe(); tick();
    rrf_freenum_i = 7'd64;
    idle(1); observe();

    // full buffer still commits
    dp1(1, 'h104, 0, 1, 5, 0, 0);
    tick();
    rrf_freenum_i = 7'd0;
    f_mul = 1; a_mul = 6'd1;
    tick();
    exp_q.push_back(mk(1, 1, 1, 5, 0, 0, 0)); observe(); tick();

    // occupancy gating
    rrf_freenum_i = 7'd64;
    dp1(2, 'h108, 0, 1, 9, 0, 0);
    dp2(3, 'h10c, 0, 1, 10, 0, 0);
    tick();
    f_alu1 = 1; a_alu1 = 6'd2; f_alu2 = 1; a_alu2 = 6'd3;
    tick();
    idle(2); observe(); tick();
    rrf_freenum_i = 7'd63;
    exp_q.push_back(mk(2, 1, 1, 9, 0, 0, 0)); observe(); tick();
    exp_q.push_back(mk(3, 1, 1, 10, 0, 0, 0)); observe(); tick();
    rrf_freenum_i = 7'd64;
    idle(4); observe();

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL leftover: observed %0d expected 0",
             exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
